// File: rtl/and_tree_sched_pkg.sv
// Shared types and width helpers for the sequential AND-tree evaluator.
// Holds the FSM state enum, a safe clog2 and the level-offset helper.
package and_tree_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width; never below 1 so N=2 still has a real k register.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Nodes finished before the level whose width is w:
  // n/2 + n/4 + ... + w collapses to n - w.
  function automatic int lvl_base(input int n, input int w);
    return n - w;
  endfunction

endpackage

// File: rtl/and_tree_sched_if.sv
// Request/result bundle of the AND-tree evaluator.
// master drives start/pi, slave returns busy/done/po0.
interface and_tree_sched_if #(
  parameter int N_LEAVES = 8
);
  logic                start;
  logic [N_LEAVES-1:0] pi;
  logic                busy;
  logic                done;
  logic                po0;

  modport master (
    output start, pi,
    input  busy, done, po0
  );

  modport slave (
    input  start, pi,
    output busy, done, po0
  );
endinterface

// File: rtl/and_tree_sched_node.sv
// Shared 2-input tree node: y = a & (b ^ inv).
// Ports: a, b operands; inv inverts b (root only); y result.
module and_node (
  input  logic a,
  input  logic b,
  input  logic inv,
  output logic y
);
  assign y = a & (b ^ inv);
endmodule

// File: rtl/and_tree_sched.sv
// Sequential AND-tree evaluator: one shared node, one node per cycle.
// Ports: clk, rst (async high), bus (slave: start/pi in; busy/done/po0 out).
module and_tree_sched
  import and_tree_sched_pkg::*;
#(
  parameter int N_LEAVES = 8,
  parameter bit ROOT_INV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  and_tree_sched_if.slave bus
);

  localparam int KW = clog2w(N_LEAVES);
  localparam int WW = KW + 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_LEAVES - 2);
  localparam logic [WW-1:0] W_FULL = WW'(N_LEAVES);

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [WW-1:0]       w_q, w_d;
  logic [N_LEAVES-1:0] scratch_q, scratch_d;
  logic                po0_q, po0_d;

  logic [WW-1:0] base;
  logic [WW-1:0] half;
  logic [KW-1:0] j;
  logic [KW-1:0] ia;
  logic [KW-1:0] ib;
  logic          na, nb, inv, ny;
  logic          last, lvl_end;
  logic          busy_o, done_o;

  // Pair addressing for the current node; in-place since j <= 2j.
  always_comb begin
    base    = WW'(lvl_base(N_LEAVES, int'(w_q)));
    j       = k_q - base[KW-1:0];
    ia      = KW'({j, 1'b0});
    ib      = ia | KW'(1);
    na      = scratch_q[ia];
    nb      = scratch_q[ib];
    half    = w_q >> 1;
    inv     = ROOT_INV && (w_q == WW'(2));
    last    = (k_q == K_LAST);
    lvl_end = ({1'b0, j} == (half - WW'(1)));
  end

  and_node u_node (
    .a  (na),
    .b  (nb),
    .inv(inv),
    .y  (ny)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      w_q       <= W_FULL;
      scratch_q <= '0;
      po0_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      w_q       <= w_d;
      scratch_q <= scratch_d;
      po0_q     <= po0_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    w_d       = w_q;
    scratch_d = scratch_q;
    po0_d     = po0_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = EVAL;
          scratch_d = bus.pi;
          k_d       = '0;
          w_d       = W_FULL;
        end
      end
      EVAL: begin
        scratch_d[j] = ny;
        if (last) begin
          state_d = DONE;
          po0_d   = ny;
        end else begin
          k_d = k_q + KW'(1);
          if (lvl_end) w_d = half;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == EVAL);
    done_o = (state_q == DONE);
  end

  assign bus.busy = busy_o;
  assign bus.done = done_o;
  assign bus.po0  = po0_q;

endmodule

// File: tb/tb_and_tree_sched.sv
// Bench for and_tree_sched: N=8 inverted-root and N=2 plain instances.
// Table vectors, exhaustive/random sweeps and multi-cycle corner sequences.
module tb_and_tree_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  and_tree_sched_if #(.N_LEAVES(8)) b8 ();
  and_tree_sched_if #(.N_LEAVES(2)) b2 ();

  and_tree_sched #(.N_LEAVES(8), .ROOT_INV(1'b1)) u8 (
    .clk(clk), .rst(rst), .bus(b8)
  );

  and_tree_sched #(.N_LEAVES(2), .ROOT_INV(1'b0)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  typedef struct {
    logic [7:0] pi;
    logic       exp;
  } vec8_t;

  typedef struct {
    logic [1:0] pi;
    logic       exp;
  } vec2_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: AND of left half, AND of right half, combine at root.
  function automatic logic model(input logic [31:0] p, input int n,
                                 input bit rinv);
    logic l, r;
    l = 1'b1;
    r = 1'b1;
    for (int i = 0; i < n / 2; i++) l &= p[i];
    for (int i = n / 2; i < n; i++) r &= p[i];
    return l & (r ^ rinv);
  endfunction

  // One evaluation on the N=8 unit; lat counts edges after acceptance.
  task automatic run8(input logic [7:0] p, output logic res,
                      output int lat, output int bc);
    b8.pi = p;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.pi = ~p;
    lat = 0;
    bc = int'(b8.busy);
    while (b8.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      bc += int'(b8.busy);
    end
    res = b8.po0;
    @(posedge clk); #1;
  endtask

  task automatic run2(input logic [1:0] p, output logic res,
                      output int lat);
    b2.pi = p;
    b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
    lat = 0;
    while (b2.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b2.po0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec8_t       t8[8];
    vec2_t       t2[4];
    logic        res;
    int          lat, bc;
    logic [7:0]  p, cap;
    logic        dn;

    t8[0] = '{8'h0F, 1'b1};
    t8[1] = '{8'hFF, 1'b0};
    t8[2] = '{8'hF0, 1'b0};
    t8[3] = '{8'h00, 1'b0};
    t8[4] = '{8'h07, 1'b0};
    t8[5] = '{8'h1F, 1'b1};
    t8[6] = '{8'h8F, 1'b1};
    t8[7] = '{8'hEF, 1'b1};
    t2[0] = '{2'b11, 1'b1};
    t2[1] = '{2'b01, 1'b0};
    t2[2] = '{2'b10, 1'b0};
    t2[3] = '{2'b00, 1'b0};

    b8.start = 1'b0;
    b8.pi = '0;
    b2.start = 1'b0;
    b2.pi = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_po0", b8.po0, 0);
    chk("rst_po0_n2", b2.po0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run8(t8[i].pi, res, lat, bc);
      chk($sformatf("tbl_po0_%02h", t8[i].pi), res, t8[i].exp);
      chk($sformatf("tbl_lat_%02h", t8[i].pi), lat, 7);
      chk($sformatf("tbl_busy_%02h", t8[i].pi), bc, 7);
      chk($sformatf("tbl_hold_%02h", t8[i].pi), b8.po0, t8[i].exp);
    end

    for (int i = 0; i < 256; i++) begin
      run8(8'(i), res, lat, bc);
      chk($sformatf("exh_%02h", i), res, model(i, 8, 1'b1));
    end

    for (int i = 0; i < 40; i++) begin
      p = 8'($urandom);
      if (i % 4 == 0) p[3:0] = 4'hF;
      run8(p, res, lat, bc);
      chk($sformatf("rnd_po0_%02h", p), res, model(p, 8, 1'b1));
      chk($sformatf("rnd_lat_%02h", p), lat, 7);
    end

    // Reset in the 4th EVAL cycle after a result of 1 is held.
    run8(8'h0F, res, lat, bc);
    chk("pre_rst_po0", res, 1);
    b8.pi = 8'h0F;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", b8.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", b8.busy, 0);
    chk("mid_rst_po0", b8.po0, 0);
    chk("mid_rst_done", b8.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      dn |= b8.done;
      dn |= b8.busy;
    end
    chk("post_rst_quiet", dn, 0);
    run8(8'h0F, res, lat, bc);
    chk("post_rst_po0", res, 1);
    chk("post_rst_lat", lat, 7);

    // start held high, pi scrambled while evaluating.
    b8.start = 1'b1;
    for (int r = 0; r < 6; r++) begin
      cap = 8'($urandom);
      if (r % 2 == 0) cap[3:0] = 4'hF;
      b8.pi = cap;
      @(posedge clk); #1;
      chk($sformatf("b2b_acc_%0d", r), b8.busy, 1);
      dn = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        b8.pi = (c % 2 == 1) ? ~cap : 8'($urandom);
        @(posedge clk); #1;
        dn |= b8.done;
      end
      b8.pi = ~cap;
      @(posedge clk); #1;
      chk($sformatf("b2b_done_%0d", r), {dn, b8.done}, 2'b01);
      chk($sformatf("b2b_po0_%0d", r), b8.po0, model(cap, 8, 1'b1));
      b8.pi = 8'($urandom);
      @(posedge clk); #1;
      chk($sformatf("b2b_idle_%0d", r), {b8.busy, b8.done}, 2'b00);
    end
    b8.start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run2(t2[i].pi, res, lat);
      chk($sformatf("n2_po0_%0b", t2[i].pi), res, t2[i].exp);
      chk($sformatf("n2_lat_%0b", t2[i].pi), lat, 1);
    end
    for (int i = 0; i < 8; i++) begin
      p = 8'($urandom);
      run2(p[1:0], res, lat);
      chk($sformatf("n2_rnd_%0b", p[1:0]), res, model(p[1:0], 2, 1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
